// File: rtl/fpga_cfg_pkg.sv
// Shared types and the CRC-8 helper for the configuration-chain loader.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BYTE,
    ST_SETUP,
    ST_PULSE,
    ST_FINISH
  } cfg_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One MSB-first CRC-8 step for a single serial bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/cfg_pclk_gen.sv
// prog_clk phase timer: counts PCLK_DIV clk cycles while enabled and strobes
// phase_done_o in the last cycle of each phase.
module cfg_pclk_gen #(
  parameter int PCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_i,
  input  logic en_i,
  output logic phase_done_o
);

  localparam int CW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PCLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_done_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || phase_done_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Byte-stream to configuration-chain loader: serialises bytes MSB-first onto
// ccff_head with PCLK_DIV-paced prog_clk pulses. Optional tail CRC: CFG_TAIL_CRC_EN.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 256,
  parameter int PCLK_DIV  = 2,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] tail_crc
);

  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  cfg_state_t        state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]        byte_bit_q, byte_bit_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic prog_clk_q, prog_clk_d, ccff_head_q, ccff_head_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic phase_done, start_ok, timeout, bit_shift;

  cfg_pclk_gen #(.PCLK_DIV(PCLK_DIV)) u_pclk_gen (
    .clk          (clk),
    .rst_i        (reset),
    .en_i         ((state_q == ST_SETUP) || (state_q == ST_PULSE)),
    .phase_done_o (phase_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_bit_q  <= '0;
      wait_q      <= '0;
      prog_clk_q  <= 1'b0;
      ccff_head_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_bit_q  <= byte_bit_d;
      wait_q      <= wait_d;
      prog_clk_q  <= prog_clk_d;
      ccff_head_q <= ccff_head_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Abort overrides every other transition out of a non-idle state.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_bit_d = byte_bit_q;
    wait_d     = wait_q;
    start_ok   = 1'b0;
    timeout    = 1'b0;
    bit_shift  = 1'b0;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start && !abort) begin
          state_d   = ST_WAIT_BYTE;
          bit_cnt_d = '0;
          wait_d    = '0;
          start_ok  = 1'b1;
        end
        ST_WAIT_BYTE: begin
          if (byte_valid) begin
            shreg_d    = byte_in;
            byte_bit_d = '0;
            state_d    = ST_SETUP;
          end else if (wait_q == WAIT_LAST) begin
            timeout = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        ST_SETUP: if (phase_done) state_d = ST_PULSE;
        ST_PULSE: if (phase_done) begin
          bit_shift  = 1'b1;
          shreg_d    = {shreg_q[6:0], 1'b0};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          byte_bit_d = byte_bit_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_FINISH;
          end else if (byte_bit_q == 3'd7) begin
            state_d = ST_WAIT_BYTE;
            wait_d  = '0;
          end else begin
            state_d = ST_SETUP;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state, so data moves only on SETUP entry.
  always_comb begin
    prog_clk_d  = (state_d == ST_PULSE);
    busy_d      = (state_d == ST_WAIT_BYTE) || (state_d == ST_SETUP) || (state_d == ST_PULSE);
    ccff_head_d = ccff_head_q;
    done_d      = done_q;
    error_d     = error_q;
    if (state_d == ST_SETUP && state_q != ST_SETUP) ccff_head_d = shreg_d[7];
    if (start_ok) begin
      done_d  = 1'b0;
      error_d = 1'b0;
    end
    if (state_d == ST_FINISH && state_q != ST_FINISH) done_d = 1'b1;
    if (timeout) error_d = 1'b1;
  end

  assign byte_ready = (state_q == ST_WAIT_BYTE);
  assign prog_clk   = prog_clk_q;
  assign ccff_head  = ccff_head_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

`ifdef CFG_TAIL_CRC_EN
  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (start_ok)       crc_d = 8'h00;
    else if (bit_shift) crc_d = crc8_step(crc_q, ccff_tail);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= 8'h00;
    else       crc_q <= crc_d;
  end

  assign tail_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign tail_crc    = 8'h00;
`endif

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader (CHAIN_LEN=12, PCLK_DIV=2, TIMEOUT=20).
module tb_fpga_cfg_loader;

  localparam int CHAIN_LEN = 12;
  localparam int PCLK_DIV  = 2;
  localparam int TIMEOUT   = 20;
`ifdef CFG_TAIL_CRC_EN
  localparam logic [7:0] EXP_CRC = 8'h30;  // CRC-8/0x07 of twelve 1 bits
`else
  localparam logic [7:0] EXP_CRC = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset, start, abort, byte_valid, ccff_tail;
  logic [7:0] byte_in;
  logic       byte_ready, prog_clk, ccff_head, busy, done, error;
  logic [7:0] tail_crc;

  int checks = 0;
  int errors = 0;

  fpga_cfg_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .PCLK_DIV  (PCLK_DIV),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .prog_clk   (prog_clk),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .tail_crc   (tail_crc)
  );

  always #5 clk = ~clk;

  // Chain-side monitor: records the bit presented at each prog_clk rise and
  // counts timing violations (short low phase, wrong high length, data moving while high).
  int         rises = 0;
  int         viol  = 0;
  int         low_run = 0;
  int         high_run = 0;
  logic [63:0] bits = '0;
  logic       head_at_rise = 1'b0;

  always @(posedge prog_clk) begin
    rises++;
    bits = {bits[62:0], ccff_head};
    head_at_rise = ccff_head;
  end

  always @(negedge clk) begin
    if (reset) begin
      low_run  = 0;
      high_run = 0;
    end else if (prog_clk) begin
      if (high_run == 0 && low_run < PCLK_DIV) viol++;
      if (ccff_head !== head_at_rise) viol++;
      high_run++;
      low_run = 0;
    end else begin
      if (high_run != 0 && high_run != PCLK_DIV) viol++;
      high_run = 0;
      low_run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_seen"}, 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic run_load(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [11:0] exp_bits, input bit restart, input string tag);
    int r0, v0;
    r0 = rises;
    v0 = viol;
    do_start();
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    send_byte(b0, {tag, "_b0"});
    if (restart) begin
      do_start();
      chk({tag, "_restart_busy"}, 32'(busy), 32'd1);
    end
    send_byte(b1, {tag, "_b1"});
    wait_done(tag);
    chk({tag, "_bits"}, 32'(bits[11:0]), 32'(exp_bits));
    chk({tag, "_rises"}, 32'(rises - r0), 32'(CHAIN_LEN));
    chk({tag, "_timing"}, 32'(viol - v0), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_crc"}, 32'(tail_crc), 32'(EXP_CRC));
    $display("load %s: bits=%03h rises=%0d crc=%02h", tag, bits[11:0], rises - r0, tail_crc);
  endtask

  initial begin
    int r0, n;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    ccff_tail  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({byte_ready, prog_clk, ccff_head, busy, done, error, tail_crc}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_load(8'hA5, 8'h3C, 12'hA53, 1'b0, "ld_a5_3c");
    repeat (5) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);
    run_load(8'hFF, 8'h9F, 12'hFF9, 1'b0, "ld_ff_9f");

    // Byte timeout
    r0 = rises;
    do_start();
    chk("to_busy", 32'(busy), 32'd1);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("to_not_early", 32'(error), 32'd0);
    @(negedge clk);
    chk("to_error", 32'(error), 32'd1);
    chk("to_busy_off", 32'(busy), 32'd0);
    chk("to_no_edges", 32'(rises - r0), 32'd0);
    $display("timeout: error=%0d busy=%0d", error, busy);

    // Abort during the 5th prog_clk high phase
    r0 = rises;
    do_start();
    chk("ab_error_clr", 32'(error), 32'd0);
    send_byte(8'h5A, "ab_b0");
    n = 0;
    while ((rises - r0) < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ab_high5", 32'(prog_clk), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_pclk_low", 32'(prog_clk), 32'd0);
    chk("ab_status", 32'({busy, done, error}), 32'd0);
    repeat (40) @(negedge clk);
    chk("ab_no_edges", 32'(rises - r0), 32'd5);
    chk("ab_ready_low", 32'(byte_ready), 32'd0);
    $display("abort: rises=%0d busy=%0d done=%0d", rises - r0, busy, done);
    run_load(8'hA5, 8'h3C, 12'hA53, 1'b0, "ld_after_abort");

    // Asynchronous reset in SETUP
    do_start();
    send_byte(8'hA5, "rst_b0");
    chk("rst_pre_head", 32'(ccff_head), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async", 32'({byte_ready, prog_clk, ccff_head, busy, done, error, tail_crc}), 32'd0);
    r0 = rises;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_edges", 32'(rises - r0), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);
    $display("reset: busy=%0d prog_clk=%0d", busy, prog_clk);

    run_load(8'hA5, 8'h3C, 12'hA53, 1'b1, "ld_start_busy");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
